// File: rtl/clock_div_pkg.sv
// Shared constants, cfg request type and ratio clamp for the clock-enable divider.
package clock_div_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;
   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned VGA_PIXEL_DIV = 4;
   localparam int unsigned CHAN_W_MAX    = 4;
   localparam int unsigned DIV_W_MAX     = 32;

   typedef struct packed {
      logic [CHAN_W_MAX-1:0] chan;
      logic [DIV_W_MAX-1:0]  div;
   } cfg_req_t;

   function automatic logic [DIV_W_MAX-1:0] clamp_div(input logic [DIV_W_MAX-1:0] x);
      return (x < DIV_W_MAX'(DIV_MIN)) ? DIV_W_MAX'(DIV_MIN) : x;
   endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: counter, active/shadow ratio and registered tick/clock enables.
module clock_div_chan import clock_div_pkg::*; #(
   parameter int unsigned CntW       = CNT_W_DEFAULT,
   parameter int unsigned DefaultDiv = VGA_PIXEL_DIV
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic            sync_i,
   input  logic            acc_i,
   input  logic [CntW-1:0] acc_div_i,
   output logic            pend_o,
   output logic            tick_o,
   output logic            clk_o
);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] div_q, div_d;
   logic [CntW-1:0] shadow_q, shadow_d;
   logic            pend_q, pend_d;
   logic            tick_q, tick_d;
   logic            clk_q, clk_d;
   logic            terminal;
   logic            apply;
   logic [CntW-1:0] new_div;
   logic [CntW-1:0] half;

   assign terminal = (cnt_q == div_q - 1'b1);
   assign apply    = sync_i | (en_i & terminal);
   // A request accepted this very cycle wins over the older shadow value.
   assign new_div  = acc_i ? acc_div_i : shadow_q;

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      clk_d    = clk_q;
      half     = '0;

      if (acc_i) begin
         shadow_d = acc_div_i;
         pend_d   = 1'b1;
      end
      if (apply && (acc_i || pend_q)) begin
         div_d  = new_div;
         pend_d = 1'b0;
      end

      if (sync_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (en_i) begin
         cnt_d  = terminal ? '0 : cnt_q + 1'b1;
         // Low for ceil(D/2) cycles, high for floor(D/2).
         half   = CntW'(({1'b0, div_d} + 1'b1) >> 1);
         tick_d = (cnt_d == div_d - 1'b1);
         clk_d  = (cnt_d >= half);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         div_q    <= CntW'(DefaultDiv);
         shadow_q <= '0;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         clk_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         clk_q    <= clk_d;
      end
   end

   assign pend_o = pend_q;
   assign tick_o = tick_q;
   assign clk_o  = clk_q;

endmodule

// File: rtl/clock_div_multi.sv
// N-channel runtime-programmable clock-enable divider with common Sync and cfg handshake.
module clock_div_multi import clock_div_pkg::*; #(
   parameter int unsigned N_CHAN      = 4,
   parameter int unsigned CNT_W       = CNT_W_DEFAULT,
   parameter int unsigned DEFAULT_DIV = VGA_PIXEL_DIV,
   localparam int unsigned CHAN_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
   input  logic              Master_Clock_In,
   input  logic              Reset,
   input  logic              Enable,
   input  logic              Sync,
   input  logic              Cfg_Valid,
   output logic              Cfg_Ready,
   input  logic [CHAN_W-1:0] Cfg_Chan,
   input  logic [CNT_W-1:0]  Cfg_Div,
   output logic [N_CHAN-1:0] Pending,
   output logic [N_CHAN-1:0] Tick_Out,
   output logic [N_CHAN-1:0] Clock_Out
);

   cfg_req_t          req;
   logic [CNT_W-1:0]  div_clamped;
   logic              chan_ok;
   logic              accept;
   logic [N_CHAN-1:0] acc;

   always_comb begin
      req      = '0;
      req.chan = CHAN_W_MAX'(Cfg_Chan);
      req.div  = DIV_W_MAX'(Cfg_Div);
   end

   assign div_clamped = CNT_W'(clamp_div(req.div));
   assign chan_ok     = (32'(req.chan) < N_CHAN);

   // Out-of-range channels never match, so they read as ready and are silently dropped.
   always_comb begin
      Cfg_Ready = 1'b1;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         if (req.chan == CHAN_W_MAX'(i)) Cfg_Ready = ~Pending[i];
      end
   end

   assign accept = Cfg_Valid & Cfg_Ready & chan_ok;

   always_comb begin
      acc = '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
         acc[i] = accept & (req.chan == CHAN_W_MAX'(i));
      end
   end

   for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
      clock_div_chan #(
         .CntW       (CNT_W),
         .DefaultDiv (DEFAULT_DIV)
      ) u_chan (
         .clk_i     (Master_Clock_In),
         .rst_i     (Reset),
         .en_i      (Enable),
         .sync_i    (Sync),
         .acc_i     (acc[g]),
         .acc_div_i (div_clamped),
         .pend_o    (Pending[g]),
         .tick_o    (Tick_Out[g]),
         .clk_o     (Clock_Out[g])
      );
   end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi with five channels (Cfg_Chan=5..7 is out of range).
module tb_clock_div_multi;

   localparam int unsigned NCh = 5;

   logic           clk;
   logic           rst;
   logic           en;
   logic           sync;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [2:0]     cfg_chan;
   logic [15:0]    cfg_div;
   logic [NCh-1:0] pending;
   logic [NCh-1:0] tick;
   logic [NCh-1:0] clko;

   int n_checks = 0;
   int n_errors = 0;

   clock_div_multi #(
      .N_CHAN      (NCh),
      .CNT_W       (16),
      .DEFAULT_DIV (4)
   ) dut (
      .Master_Clock_In (clk),
      .Reset           (rst),
      .Enable          (en),
      .Sync            (sync),
      .Cfg_Valid       (cfg_valid),
      .Cfg_Ready       (cfg_ready),
      .Cfg_Chan        (cfg_chan),
      .Cfg_Div         (cfg_div),
      .Pending         (pending),
      .Tick_Out        (tick),
      .Clock_Out       (clko)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int d[NCh];
      logic [NCh-1:0] et;
      logic [NCh-1:0] ec;
      int m;
      int c1;

      rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
      step(); step();
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_clk", 32'(clko), 32'h0);
      chk("rst_pend", 32'(pending), 32'h0);
      chk("rst_ready", 32'(cfg_ready), 32'h1);

      // Defaults: D=4 on every channel, pattern 0011, tick at cnt 3.
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         m = (i + 1) % 4;
         chk("def_clk", 32'(clko), (m >= 2) ? 32'h1f : 32'h0);
         chk("def_tick", 32'(tick), (m == 3) ? 32'h1f : 32'h0);
      end

      // ch1 -> D=5 accepted mid-period, applied at next terminal count.
      step();
      cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 16'd5;
      chk("cfg1_ready_before", 32'(cfg_ready), 32'h1);
      step();
      cfg_valid = 1'b0;
      chk("cfg1_pend", 32'(pending), 32'h02);
      chk("cfg1_ready_low", 32'(cfg_ready), 32'h0);
      step();
      chk("cfg1_pend_hold", 32'(pending), 32'h02);
      chk("cfg1_tick_old", 32'(tick), 32'h1f);
      step();
      chk("cfg1_applied", 32'(pending), 32'h0);
      chk("cfg1_ready_back", 32'(cfg_ready), 32'h1);
      for (int i = 0; i < 10; i++) begin
         step();
         c1 = (i + 1) % 5;
         chk("d5_clk", 32'(clko[1]), (c1 >= 3) ? 32'h1 : 32'h0);
         chk("d5_tick", 32'(tick[1]), (c1 == 4) ? 32'h1 : 32'h0);
      end

      // D=0 on ch2 (pending), D=1 on ch3 accepted on its terminal cycle (applied at once).
      cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 16'd0;
      step();
      chk("clamp0_pend", 32'(pending), 32'h04);
      cfg_chan = 3'd3; cfg_div = 16'd1;
      step();
      cfg_valid = 1'b0;
      chk("clamp_term_pend", 32'(pending), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("d2_clk", 32'(clko[3:2]), (i % 2 == 0) ? 32'h3 : 32'h0);
         chk("d2_tick", 32'(tick[3:2]), (i % 2 == 0) ? 32'h3 : 32'h0);
      end
      cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_div = 16'd9;
      step();
      chk("oor5_pend", 32'(pending), 32'h0);
      cfg_chan = 3'd7;
      step();
      chk("oor7_pend", 32'(pending), 32'h0);
      cfg_valid = 1'b0;

      // Sync, then freeze at cnt=2 with an accept while disabled.
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_tick", 32'(tick), 32'h0);
      chk("sync_clk", 32'(clko), 32'h0);
      step(); step();
      chk("pre_freeze_clk", 32'(clko), 32'h11);
      en = 1'b0; cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 16'd4;
      for (int i = 0; i < 7; i++) begin
         step();
         cfg_valid = 1'b0;
         chk("freeze_clk", 32'(clko), 32'h11);
         chk("freeze_tick", 32'(tick), 32'h0);
         chk("freeze_pend", 32'(pending), 32'h04);
      end
      en = 1'b1;
      step();
      chk("resume_clk", 32'(clko), 32'h1f);
      chk("resume_tick", 32'(tick), 32'h1d);
      chk("resume_pend", 32'(pending), 32'h04);

      // Build D = 3/5/4/7/4, then Sync with ch0 D=6 pending.
      cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 16'd3;
      step();
      chk("e1_pend", 32'(pending), 32'h0);
      chk("e1_tick", 32'(tick), 32'h02);
      cfg_chan = 3'd3; cfg_div = 16'd7;
      step();
      chk("e2_pend", 32'(pending), 32'h08);
      cfg_valid = 1'b0;
      step();
      chk("e3_pend", 32'(pending), 32'h0);
      chk("e3_tick", 32'(tick), 32'h01);
      for (int i = 0; i < 5; i++) step();
      cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 16'd6;
      step();
      cfg_valid = 1'b0;
      chk("e9_pend", 32'(pending), 32'h01);
      chk("e9_ready", 32'(cfg_ready), 32'h0);
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync2_pend", 32'(pending), 32'h0);
      chk("sync2_tick", 32'(tick), 32'h0);
      chk("sync2_clk", 32'(clko), 32'h0);
      d[0] = 6; d[1] = 5; d[2] = 4; d[3] = 7; d[4] = 4;
      for (int k = 1; k <= 420; k++) begin
         step();
         et = '0;
         ec = '0;
         for (int c = 0; c < NCh; c++) begin
            m = k % d[c];
            et[c] = (m == d[c] - 1);
            ec[c] = (m >= (d[c] + 1) / 2);
         end
         chk("lcm_tick", 32'(tick), 32'(et));
         chk("lcm_clk", 32'(clko), 32'(ec));
         if (k == 419) chk("lcm_coincide", 32'(tick), 32'h1f);
      end

      // Reset with ch2 pending and Cfg_Valid held throughout.
      cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 16'd9;
      step();
      chk("r_pend_set", 32'(pending), 32'h04);
      chk("r_ready_low", 32'(cfg_ready), 32'h0);
      rst = 1'b1;
      step();
      chk("r_pend_clr", 32'(pending), 32'h0);
      chk("r_tick", 32'(tick), 32'h0);
      chk("r_clk", 32'(clko), 32'h0);
      step();
      chk("r_no_accept", 32'(pending), 32'h0);
      rst = 1'b0;
      step();
      cfg_valid = 1'b0;
      chk("r_accept_first", 32'(pending), 32'h04);
      step();
      chk("r_d4_clk", 32'(clko), 32'h1f);
      step();
      chk("r_d4_tick", 32'(tick), 32'h1f);
      step();
      chk("r_apply9", 32'(pending), 32'h0);
      for (int i = 0; i < 8; i++) step();
      chk("d9_tick", 32'(tick), 32'h04);
      chk("d9_clk", 32'(clko), 32'h04);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
